// File: rtl/seven_seg_bcd_display.sv
// seven_seg_bcd_display
// Converts an unsigned binary value to BCD with a bit-serial double-dabble
// engine (one input bit per clock). The result drives DIGITS active-low
// seven-segment digits. Features: leading-zero blanking, overflow dashes
// and a free-running blink generator.
module seven_seg_bcd_display #(
  parameter int WIDTH     = 16,
  parameter int DIGITS    = 5,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [WIDTH-1:0]      i_value,
  input  logic                  i_load,
  input  logic                  i_show,
  input  logic                  i_blank_lz,
  input  logic                  i_blink,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic [7*DIGITS-1:0]   o_seven
);

  // Nibbles needed to hold any WIDTH-bit value: ceil(WIDTH*log10(2) + 1).
  localparam int NIB    = (WIDTH * 30103 + 199999) / 100000;
  // The accumulator is never narrower than the display. Any extra nibbles
  // stay zero and behave exactly like display padding.
  localparam int ACC_N  = (NIB > DIGITS) ? NIB : DIGITS;
  localparam int ACC_W  = 4 * ACC_N;
  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int BDIV_W = $clog2(BLINK_DIV);

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  // Largest value the display can show: 10**DIGITS - 1, held in 64 bits
  // because 10**10 does not fit in 32 bits.
  function automatic logic [63:0] pow10_minus1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10_minus1(DIGITS);

  // Active-low segment patterns. Codes 10..15 cannot occur and decode dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1011000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_OFF;
    endcase
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [WIDTH-1:0]    bin_reg, bin_next;
  logic [ACC_W-1:0]    bcd_reg, bcd_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                ovf_pend_reg, ovf_pend_next;
  logic [4*DIGITS-1:0] disp_reg, disp_next;
  logic                overflow_reg, overflow_next;
  logic                done_reg, done_next;

  logic [BDIV_W-1:0]   blink_cnt_reg;
  logic                phase_hidden_reg;
  logic [7*DIGITS-1:0] seven_reg, seven_next;

  logic [ACC_W-1:0]    bcd_adj;
  logic [ACC_W-1:0]    bcd_shift;
  logic [WIDTH-1:0]    bin_shift;
  logic [63:0]         value_ext;
  logic                dark;

  assign value_ext = 64'(i_value);

  // Double-dabble correction: every nibble of 5 or more gets +3 before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < ACC_N; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  (bcd_reg[4*gi +: 4] + 4'd3) :
                                  bcd_reg[4*gi +: 4];
    end
  endgenerate

  // Shift {bcd, bin} left by one; the binary MSB enters the BCD LSB.
  assign bcd_shift = {bcd_adj[ACC_W-2:0], bin_reg[WIDTH-1]};
  assign bin_shift = {bin_reg[WIDTH-2:0], 1'b0};

  // Conversion FSM: next-state logic and datapath updates.
  always_comb begin
    state_next    = state_reg;
    bin_next      = bin_reg;
    bcd_next      = bcd_reg;
    cnt_next      = cnt_reg;
    ovf_pend_next = ovf_pend_reg;
    disp_next     = disp_reg;
    overflow_next = overflow_reg;
    done_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_load) begin
          bin_next      = i_value;
          bcd_next      = '0;
          cnt_next      = '0;
          ovf_pend_next = (value_ext > MAX_VAL);
          state_next    = CONV;
        end
      end
      CONV: begin
        bin_next = bin_shift;
        bcd_next = bcd_shift;
        cnt_next = cnt_reg + 1'b1;
        // A carry out of the top nibble would mean the accumulator is too
        // small. Fold it into overflow so a wrong value is never shown as valid.
        ovf_pend_next = ovf_pend_reg | bcd_adj[ACC_W-1];
        if (cnt_reg == CNT_W'(WIDTH - 1)) begin
          disp_next     = bcd_shift[4*DIGITS-1:0];
          overflow_next = ovf_pend_reg | bcd_adj[ACC_W-1];
          done_next     = 1'b1;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Conversion FSM state and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      bin_reg      <= '0;
      bcd_reg      <= '0;
      cnt_reg      <= '0;
      ovf_pend_reg <= 1'b0;
      disp_reg     <= '0;
      overflow_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bin_reg      <= bin_next;
      bcd_reg      <= bcd_next;
      cnt_reg      <= cnt_next;
      ovf_pend_reg <= ovf_pend_next;
      disp_reg     <= disp_next;
      overflow_reg <= overflow_next;
      done_reg     <= done_next;
    end
  end

  // Free-running blink divider. The phase toggles on every wrap, even while
  // blinking is disabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      blink_cnt_reg    <= '0;
      phase_hidden_reg <= 1'b0;
    end else if (blink_cnt_reg == BDIV_W'(BLINK_DIV - 1)) begin
      blink_cnt_reg    <= '0;
      phase_hidden_reg <= ~phase_hidden_reg;
    end else begin
      blink_cnt_reg    <= blink_cnt_reg + 1'b1;
    end
  end

  assign dark = !i_show || (i_blink && phase_hidden_reg);

  // Per-digit output selection. Priority: dark, overflow dashes,
  // leading-zero blanking, then decoded digit. Digit 0 is never blanked.
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] nib;
      logic       blank;
      assign nib = disp_reg[4*gi +: 4];
      if (gi == 0) begin : g_lsd
        assign blank = 1'b0;
      end else begin : g_upper
        assign blank = i_blank_lz && (disp_reg[4*DIGITS-1:4*gi] == '0);
      end
      assign seven_next[7*gi +: 7] = dark         ? SEG_OFF  :
                                     overflow_reg ? SEG_DASH :
                                     blank        ? SEG_OFF  :
                                     seg_decode(nib);
    end
  endgenerate

  // Registered segment outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seven_reg <= '1;
    end else begin
      seven_reg <= seven_next;
    end
  end

  assign o_busy     = (state_reg == CONV);
  assign o_done     = done_reg;
  assign o_overflow = overflow_reg;
  assign o_seven    = seven_reg;

endmodule

// File: tb/tb_seven_seg_bcd_display.sv
// Testbench for seven_seg_bcd_display. Two instances share the same inputs:
// a 5-digit one and a 4-digit one, so the 4-digit instance can reach overflow
// with 16-bit inputs. Expected segment patterns come from a decimal model.
module tb_seven_seg_bcd_display;

  localparam int W  = 16;
  localparam int BD = 4;

  logic clk;
  logic rst_n;
  logic [W-1:0] value;
  logic load, show, blank_lz, blink;

  logic busy5, done5, ovf5;
  logic [34:0] seven5;
  logic busy4, done4, ovf4;
  logic [27:0] seven4;

  int tests_run = 0;
  int fails = 0;
  int edge_cnt;
  int unsigned m_val;

  seven_seg_bcd_display #(.WIDTH(W), .DIGITS(5), .BLINK_DIV(BD)) dut5 (
    .i_clk(clk), .i_rst_n(rst_n), .i_value(value), .i_load(load),
    .i_show(show), .i_blank_lz(blank_lz), .i_blink(blink),
    .o_busy(busy5), .o_done(done5), .o_overflow(ovf5), .o_seven(seven5)
  );

  seven_seg_bcd_display #(.WIDTH(W), .DIGITS(4), .BLINK_DIV(BD)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_value(value), .i_load(load),
    .i_show(show), .i_blank_lz(blank_lz), .i_blink(blink),
    .o_busy(busy4), .o_done(done4), .o_overflow(ovf4), .o_seven(seven4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges since reset was released; used to derive the blink phase.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  // The output sampled after edge m used the phase from m-1 edges.
  // The phase flips every BD edges.
  function automatic bit hidden_now();
    if (edge_cnt == 0) return 1'b0;
    return (((edge_cnt - 1) / BD) % 2) == 1;
  endfunction

  function automatic logic [34:0] exp_seven(int unsigned v, int nd, bit shw,
                                            bit hid, bit blk);
    logic [6:0] codes [10];
    logic [34:0] r;
    logic [6:0] seg;
    int unsigned p;
    bit ovf;
    codes = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1011000, 7'b0000000, 7'b0010000};
    r = '1;
    p = 1;
    ovf = 1'b0;
    for (int k = 0; k < nd; k++) p = p * 10;
    ovf = (v >= p);
    p = 1;
    for (int k = 0; k < nd; k++) begin
      if (!shw || hid)               seg = 7'b1111111;
      else if (ovf)                  seg = 7'b0111111;
      else if (blk && k > 0 && v < p) seg = 7'b1111111;
      else                           seg = codes[(v / p) % 10];
      r[7*k +: 7] = seg;
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [34:0] exp5();
    return exp_seven(m_val, 5, show, blink && hidden_now(), blank_lz);
  endfunction

  function automatic logic [27:0] exp4();
    logic [34:0] t;
    t = exp_seven(m_val, 4, show, blink && hidden_now(), blank_lz);
    return t[27:0];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; value = '0; load = 1'b0; show = 1'b1; blank_lz = 1'b0; blink = 1'b0;
    m_val = 0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (seven5 !== '1 || seven4 !== '1) begin
      fails++; $display("FAIL reset_seven: got %h/%h expected all ones", seven5, seven4);
    end
    tests_run++;
    if (busy5 !== 1'b0 || ovf5 !== 1'b0 || done5 !== 1'b0 || busy4 !== 1'b0 || ovf4 !== 1'b0) begin
      fails++; $display("FAIL reset_flags: got busy=%b ovf=%b done=%b expected 0", busy5, ovf5, done5);
    end
    rst_n = 1'b1;
    show = 1'b0;
    @(negedge clk);
    tests_run++;
    if (seven5 !== '1 || seven4 !== '1) begin
      fails++; $display("FAIL idle_show0: got %h expected all ones", seven5);
    end
    show = 1'b1;
    @(negedge clk);
    tests_run++;
    if (seven5 !== exp5() || seven4 !== exp4()) begin
      fails++; $display("FAIL idle_zero: got %h expected %h", seven5, exp5());
    end
    $display("[TB] reset checks done");
  endtask

  // Loads v and checks the busy window, done pulse, overflow flags and
  // the display (old value while converting, new value afterwards).
  task automatic load_and_check(input int unsigned v);
    int bad;
    @(negedge clk);
    value = W'(v); load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    bad = 0;
    for (int i = 0; i < W; i++) begin
      if (busy5 !== 1'b1 || busy4 !== 1'b1 || done5 !== 1'b0 || done4 !== 1'b0) bad++;
      if (seven5 !== exp5() || seven4 !== exp4()) bad++;
      @(negedge clk);
    end
    tests_run++;
    if (bad != 0) begin
      fails++; $display("FAIL busy_window v=%0d: got %0d bad cycles expected 0", v, bad);
    end
    tests_run++;
    if (busy5 !== 1'b0 || done5 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b1) begin
      fails++; $display("FAIL done_pulse v=%0d: got busy=%b done=%b expected busy=0 done=1", v, busy5, done5);
    end
    m_val = v;
    tests_run++;
    if (ovf5 !== (v > 99999) || ovf4 !== (v > 9999)) begin
      fails++; $display("FAIL overflow v=%0d: got %b/%b expected %b/%b", v, ovf5, ovf4, v > 99999, v > 9999);
    end
    @(negedge clk);
    tests_run++;
    if (seven5 !== exp5() || seven4 !== exp4() || done5 !== 1'b0) begin
      fails++; $display("FAIL display v=%0d: got %h/%h expected %h/%h", v, seven5, seven4, exp5(), exp4());
    end
    $display("[TB] load %0d show=%b blank=%b -> %h / %h", v, show, blank_lz, seven5, seven4);
  endtask

  task automatic test_known_values();
    logic [34:0] e;
    show = 1'b1; blank_lz = 1'b0;
    load_and_check(12345);
    e = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010};
    tests_run++;
    if (seven5 !== e) begin
      fails++; $display("FAIL digits_12345: got %h expected %h", seven5, e);
    end
    tests_run++;
    if (seven4 !== {4{7'b0111111}}) begin
      fails++; $display("FAIL dash_12345: got %h expected %h", seven4, {4{7'b0111111}});
    end
    blank_lz = 1'b1;
    load_and_check(7);
    e = {{4{7'b1111111}}, 7'b1011000};
    tests_run++;
    if (seven5 !== e) begin
      fails++; $display("FAIL blank_7: got %h expected %h", seven5, e);
    end
    blank_lz = 1'b0;
    @(negedge clk);
    e = {{4{7'b1000000}}, 7'b1011000};
    tests_run++;
    if (seven5 !== e) begin
      fails++; $display("FAIL noblank_7: got %h expected %h", seven5, e);
    end
    blank_lz = 1'b1;
    load_and_check(0);
    tests_run++;
    if (seven5 !== {{4{7'b1111111}}, 7'b1000000}) begin
      fails++; $display("FAIL zero_digit0: got %h expected digit0=0 only", seven5);
    end
  endtask

  task automatic test_overflow();
    show = 1'b1; blank_lz = 1'b1;
    load_and_check(10000);
    tests_run++;
    if (ovf4 !== 1'b1 || seven4 !== {4{7'b0111111}}) begin
      fails++; $display("FAIL ovf_10000: got ovf=%b seg=%h expected ovf=1 dashes", ovf4, seven4);
    end
    load_and_check(9999);
    tests_run++;
    if (ovf4 !== 1'b0 || seven4 !== {4{7'b0010000}}) begin
      fails++; $display("FAIL ovf_9999: got ovf=%b seg=%h expected ovf=0 9999", ovf4, seven4);
    end
  endtask

  task automatic test_ignore_midconv();
    int done_count;
    show = 1'b1; blank_lz = 1'b0;
    @(negedge clk);
    value = 16'd42; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    done_count = 0;
    for (int i = 1; i <= 25; i++) begin
      if (done5 === 1'b1) done_count++;
      if (i == 5) begin value = 16'd99; load = 1'b1; end
      else        load = 1'b0;
      @(negedge clk);
    end
    load = 1'b0;
    m_val = 42;
    tests_run++;
    if (done_count != 1) begin
      fails++; $display("FAIL ignore_done_count: got %0d expected 1", done_count);
    end
    tests_run++;
    if (seven5 !== exp5() || seven4 !== exp4()) begin
      fails++; $display("FAIL ignore_display: got %h expected %h", seven5, exp5());
    end
    $display("[TB] mid-conversion load ignored, done pulses=%0d", done_count);
  endtask

  task automatic test_back_to_back();
    show = 1'b1; blank_lz = 1'b1;
    @(negedge clk);
    value = 16'd1234; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (W) @(negedge clk);
    tests_run++;
    if (done5 !== 1'b1) begin
      fails++; $display("FAIL b2b_first_done: got %b expected 1", done5);
    end
    value = 16'd56789; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    m_val = 1234;
    tests_run++;
    if (busy5 !== 1'b1 || busy4 !== 1'b1 || seven5 !== exp5()) begin
      fails++; $display("FAIL b2b_accept: got busy=%b seg=%h expected busy=1 seg=%h", busy5, seven5, exp5());
    end
    repeat (W) @(negedge clk);
    tests_run++;
    if (done5 !== 1'b1) begin
      fails++; $display("FAIL b2b_second_done: got %b expected 1", done5);
    end
    m_val = 56789;
    @(negedge clk);
    tests_run++;
    if (seven5 !== exp5() || seven4 !== exp4()) begin
      fails++; $display("FAIL b2b_display: got %h/%h expected %h/%h", seven5, seven4, exp5(), exp4());
    end
    $display("[TB] back-to-back load 1234 then 56789 -> %h", seven5);
  endtask

  task automatic test_random();
    int unsigned v;
    for (int n = 0; n < 20; n++) begin
      v = $urandom_range(0, 65535) >> $urandom_range(0, 15);
      show = ($urandom_range(0, 7) != 0);
      blank_lz = 1'($urandom_range(0, 1));
      load_and_check(v);
    end
  endtask

  task automatic test_blink();
    int dark_cycles;
    show = 1'b1; blank_lz = 1'b0;
    load_and_check(31416);
    @(negedge clk);
    blink = 1'b1;
    dark_cycles = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      tests_run++;
      if (seven5 !== exp5() || seven4 !== exp4()) begin
        fails++; $display("FAIL blink_cycle%0d: got %h expected %h", i, seven5, exp5());
      end
      if (seven5 === '1) dark_cycles++;
    end
    tests_run++;
    if (dark_cycles != 12) begin
      fails++; $display("FAIL blink_duty: got %0d dark cycles expected 12", dark_cycles);
    end
    show = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests_run++;
      if (seven5 !== '1 || seven4 !== '1) begin
        fails++; $display("FAIL blink_show0_%0d: got %h expected all ones", i, seven5);
      end
    end
    show = 1'b1; blink = 1'b0;
    $display("[TB] blink dark cycles=%0d of 24", dark_cycles);
  endtask

  task automatic test_reset_midconv();
    show = 1'b1; blank_lz = 1'b0;
    load_and_check(10000);
    @(negedge clk);
    value = 16'd30000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy5 !== 1'b0 || busy4 !== 1'b0 || ovf4 !== 1'b0 || done5 !== 1'b0) begin
      fails++; $display("FAIL async_reset_flags: got busy=%b ovf4=%b expected 0", busy5, ovf4);
    end
    tests_run++;
    if (seven5 !== '1 || seven4 !== '1) begin
      fails++; $display("FAIL async_reset_seven: got %h/%h expected all ones", seven5, seven4);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_val = 0;
    @(negedge clk);
    tests_run++;
    if (seven5 !== exp5() || seven4 !== exp4() || busy5 !== 1'b0) begin
      fails++; $display("FAIL post_reset_display: got %h expected %h", seven5, exp5());
    end
    $display("[TB] reset during conversion -> %h", seven5);
  endtask

  initial begin
    test_reset();
    test_known_values();
    test_overflow();
    test_ignore_midconv();
    test_back_to_back();
    test_random();
    test_blink();
    test_reset_midconv();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
